// File: rtl/simt_pc_unit.sv
// Program counter, lane mask and reconvergence stack for the SIMT core.
// Divergent vector branches run the taken path first, then the not-taken path; SYNC pops the stack.
module simt_pc_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0,
  parameter int          THREADS     = 4,
  parameter int          STACK_DEPTH = 8,
  localparam int         DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               iHit,
  input  logic               halt,
  input  logic [1:0]         pc_sel,
  input  logic               brEn,
  input  logic [31:0]        immExt,
  input  logic [25:0]        jaddr,
  input  logic [31:0]        rdata1,
  input  logic               vbr,
  input  logic [THREADS-1:0] vcond,
  input  logic               reconv,
  output logic [31:0]        pc,
  output logic [THREADS-1:0] active_mask,
  output logic [DW-1:0]      depth,
  output logic               dhalt,
  output logic               stack_overflow
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [31:0]        pc_q, pc_d;
  logic [THREADS-1:0] mask_q, mask_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               dhalt_q, dhalt_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        stk_pc_q   [STACK_DEPTH];
  logic [31:0]        stk_pc_d   [STACK_DEPTH];
  logic [THREADS-1:0] stk_nt_q   [STACK_DEPTH];
  logic [THREADS-1:0] stk_nt_d   [STACK_DEPTH];
  logic [THREADS-1:0] stk_full_q [STACK_DEPTH];
  logic [THREADS-1:0] stk_full_d [STACK_DEPTH];
  logic               stk_pend_q [STACK_DEPTH];
  logic               stk_pend_d [STACK_DEPTH];

  // iHit is a one-sided advance strobe: every input is consumed on an edge where iHit=1 and the core is not halted.
  logic               adv;
  logic [31:0]        seq, tgt;
  logic [THREADS-1:0] tk, nt;
  logic [IW-1:0]      top_idx, push_idx;
  logic               full;

  assign adv      = iHit & ~dhalt_q;
  assign seq      = pc_q + 32'd4;
  assign tgt      = seq + (immExt << 2);
  assign tk       = vcond & mask_q;
  assign nt       = ~vcond & mask_q;
  assign top_idx  = IW'(depth_q - DW'(1));
  assign push_idx = IW'(depth_q);
  assign full     = (depth_q == DW'(STACK_DEPTH));

  always_comb begin
    pc_d       = pc_q;
    mask_d     = mask_q;
    depth_d    = depth_q;
    dhalt_d    = dhalt_q;
    ovf_d      = ovf_q;
    stk_pc_d   = stk_pc_q;
    stk_nt_d   = stk_nt_q;
    stk_full_d = stk_full_q;
    stk_pend_d = stk_pend_q;
    if (adv) begin
      if (halt) begin
        dhalt_d = 1'b1;
      end else if (vbr) begin
        if (tk == '0) begin
          pc_d = seq;
        end else if (nt == '0) begin
          pc_d = tgt;
        end else if (!full) begin
          stk_pc_d[push_idx]   = seq;
          stk_nt_d[push_idx]   = nt;
          stk_full_d[push_idx] = mask_q;
          stk_pend_d[push_idx] = 1'b1;
          pc_d    = tgt;
          mask_d  = tk;
          depth_d = depth_q + DW'(1);
        end else begin
          // No room to record the not-taken path: stop the core rather than lose lanes.
          ovf_d   = 1'b1;
          dhalt_d = 1'b1;
        end
      end else if (reconv) begin
        if (depth_q == '0) begin
          pc_d = seq;
        end else if (stk_pend_q[top_idx]) begin
          pc_d                = stk_pc_q[top_idx];
          mask_d              = stk_nt_q[top_idx];
          stk_pend_d[top_idx] = 1'b0;
        end else begin
          pc_d    = seq;
          mask_d  = stk_full_q[top_idx];
          depth_d = depth_q - DW'(1);
        end
      end else begin
        case (pc_sel)
          2'b01:   pc_d = rdata1;
          2'b10:   pc_d = {pc_q[31:28], jaddr, 2'b00};
          default: pc_d = brEn ? tgt : seq;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q    <= PC_INIT;
      mask_q  <= '1;
      depth_q <= '0;
      dhalt_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_pc_q[i]   <= '0;
        stk_nt_q[i]   <= '0;
        stk_full_q[i] <= '0;
        stk_pend_q[i] <= 1'b0;
      end
    end else begin
      pc_q       <= pc_d;
      mask_q     <= mask_d;
      depth_q    <= depth_d;
      dhalt_q    <= dhalt_d;
      ovf_q      <= ovf_d;
      stk_pc_q   <= stk_pc_d;
      stk_nt_q   <= stk_nt_d;
      stk_full_q <= stk_full_d;
      stk_pend_q <= stk_pend_d;
    end
  end

  assign pc             = pc_q;
  assign active_mask    = mask_q;
  assign depth          = depth_q;
  assign dhalt          = dhalt_q;
  assign stack_overflow = ovf_q;

endmodule

// File: tb/tb_simt_pc_unit.sv
// Bench for simt_pc_unit with a two-entry stack: vector table plus reset/jump/halt sequences.
module tb_simt_pc_unit;
  localparam int THREADS     = 4;
  localparam int STACK_DEPTH = 2;
  localparam int DW          = $clog2(STACK_DEPTH + 1);
  localparam int EW          = 32 + THREADS + DW + 2;

  logic               CLK = 1'b0;
  logic               nRST;
  logic               iHit, halt, brEn, vbr, reconv;
  logic [1:0]         pc_sel;
  logic [31:0]        immExt, rdata1;
  logic [25:0]        jaddr;
  logic [THREADS-1:0] vcond;
  logic [31:0]        pc;
  logic [THREADS-1:0] active_mask;
  logic [DW-1:0]      depth;
  logic               dhalt, stack_overflow;

  int passed = 0;
  int total  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic               ihit, halt;
    logic [1:0]         pc_sel;
    logic               br_en;
    logic [31:0]        imm;
    logic [25:0]        jaddr;
    logic [31:0]        rdata1;
    logic               vbr;
    logic [THREADS-1:0] vcond;
    logic               reconv;
    logic [EW-1:0]      exp;
  } vec_t;

  vec_t tbl[$];

  simt_pc_unit #(.PC_INIT(32'h0), .THREADS(THREADS), .STACK_DEPTH(STACK_DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .iHit(iHit), .halt(halt), .pc_sel(pc_sel), .brEn(brEn),
    .immExt(immExt), .jaddr(jaddr), .rdata1(rdata1), .vbr(vbr), .vcond(vcond),
    .reconv(reconv), .pc(pc), .active_mask(active_mask), .depth(depth), .dhalt(dhalt),
    .stack_overflow(stack_overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input int ih, input int hl, input int sel, input int br,
                               input int imm, input int ja, input int rd, input int vb,
                               input int vc, input int rc, input int epc, input int em,
                               input int ed, input int edh, input int eov);
    vec_t v;
    v.ihit = 1'(ih); v.halt = 1'(hl); v.pc_sel = 2'(sel); v.br_en = 1'(br);
    v.imm = 32'(imm); v.jaddr = 26'(ja); v.rdata1 = 32'(rd); v.vbr = 1'(vb);
    v.vcond = THREADS'(vc); v.reconv = 1'(rc);
    v.exp = {32'(epc), THREADS'(em), DW'(ed), 1'(edh), 1'(eov)};
    return v;
  endfunction

  task automatic check(input int idx, input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL step %0d %s: got %h, want %h", idx, nm, got, want);
    else passed++;
  endtask

  task automatic compare_top(input int idx);
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check(idx, "pc",             pc,                    e[EW-1 -: 32]);
    check(idx, "active_mask",    32'(active_mask),      32'(e[EW-33 -: THREADS]));
    check(idx, "depth",          32'(depth),            32'(e[DW+1:2]));
    check(idx, "dhalt",          32'(dhalt),            32'(e[1]));
    check(idx, "stack_overflow", 32'(stack_overflow),   32'(e[0]));
  endtask

  task automatic drive_idle();
    iHit = 1'b0; halt = 1'b0; pc_sel = 2'b00; brEn = 1'b0; immExt = '0;
    jaddr = '0; rdata1 = '0; vbr = 1'b0; vcond = '0; reconv = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    iHit = v.ihit; halt = v.halt; pc_sel = v.pc_sel; brEn = v.br_en; immExt = v.imm;
    jaddr = v.jaddr; rdata1 = v.rdata1; vbr = v.vbr; vcond = v.vcond; reconv = v.reconv;
    exp_q.push_back(v.exp);
    @(posedge CLK);
    #1;
    compare_top(idx);
  endtask

  // Reset is asserted between edges and checked before any clock edge sees it.
  task automatic do_reset(input int idx);
    #2;
    drive_idle();
    nRST = 1'b0;
    exp_q.push_back({32'h0, {THREADS{1'b1}}, DW'(0), 1'b0, 1'b0});
    #1;
    compare_top(idx);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    drive_idle();

    //                ih hl sel br imm ja rd        vb vc   rc  epc    em   ed dh ov
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h04, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h08, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h0C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 4,  0, 0,        1, 'h5, 0,  'h0C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0,  0, 'h80,     0, 0,   0,  'h0C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h10, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 3,  0, 0,        1, 'hF, 0,  'h20, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0,  0, 'h10,     0, 0,   0,  'h10, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 3,  0, 0,        1, 'h0, 0,  'h14, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0,  0, 'h10,     0, 0,   0,  'h10, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 4,  0, 0,        1, 'h5, 1,  'h24, 'h5, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h14, 'hA, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h18, 'hA, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h1C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0,  0, 'h100,    0, 0,   1,  'h20, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 1,  0, 0,        0, 0,   0,  'h28, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 3, 0, 1,  0, 0,        0, 0,   0,  'h2C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, -1, 0, 0,        0, 0,   0,  'h2C, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        1, 'h3, 0,  'h30, 'h3, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 1,  0, 0,        1, 'h1, 0,  'h38, 'h1, 2, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h34, 'h2, 2, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h38, 'h3, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h30, 'hC, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 5,  0, 0,        1, 'h3, 0,  'h34, 'hC, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 1,  0, 0,        1, 'hC, 0,  'h3C, 'hC, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h40, 'hF, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        1, 'h7, 0,  'h44, 'h7, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        1, 'h3, 0,  'h48, 'h3, 2, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        1, 'h2, 0,  'h48, 'h3, 2, 1, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   0,  'h48, 'h3, 2, 1, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0, 0,        0, 0,   1,  'h48, 'h3, 2, 1, 1));

    do_reset(0);
    foreach (tbl[i]) apply(tbl[i], i + 1);

    // Jumps, address wrap and sticky halt.
    do_reset(100);
    apply(mkv(1, 0, 1, 0, 0, 0,          'h100,       0, 0,   0, 'h100,       'hF, 0, 0, 0), 101);
    apply(mkv(1, 0, 2, 0, 0, 'h40,       0,           0, 0,   0, 'h100,       'hF, 0, 0, 0), 102);
    apply(mkv(1, 0, 1, 0, 0, 0,          'hF0000000,  0, 0,   0, 'hF0000000,  'hF, 0, 0, 0), 103);
    apply(mkv(1, 0, 2, 0, 0, 'h3FFFFFF,  0,           0, 0,   0, 'hFFFFFFFC,  'hF, 0, 0, 0), 104);
    apply(mkv(1, 0, 0, 0, 0, 0,          0,           0, 0,   0, 'h0,         'hF, 0, 0, 0), 105);
    apply(mkv(1, 1, 0, 0, 4, 0,          0,           1, 'h5, 0, 'h0,         'hF, 0, 1, 0), 106);
    for (int k = 0; k < 5; k++)
      apply(mkv(1, 0, 1, 0, 0, 0, 'h200, 0, 0, 0, 'h0, 'hF, 0, 1, 0), 107 + k);

    // Reset in the middle of a divergence discards the stack.
    do_reset(200);
    apply(mkv(1, 0, 1, 0, 0, 0, 'h10, 0, 0,   0, 'h10, 'hF, 0, 0, 0), 201);
    apply(mkv(1, 0, 0, 0, 4, 0, 0,    1, 'h5, 0, 'h24, 'h5, 1, 0, 0), 202);
    do_reset(203);
    apply(mkv(1, 0, 0, 0, 0, 0, 0,    0, 0,   1, 'h4,  'hF, 0, 0, 0), 204);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simt_pc_unit.md
# simt_pc_unit

Parametrised program-counter and thread-mask unit for the SIMD/SIMT core. It replaces the fixed 4-thread PC register and next-PC mux inside the datapath, and adds per-lane divergence for vector branches. A reconvergence stack of depth STACK_DEPTH serialises the taken and not-taken paths, and `active_mask` gates register, memory and ALU writes per lane. It sits between the control unit and the instruction-fetch side of the load/store unit.

## Interface
- PC_INIT, 0: PC value loaded on reset.
- THREADS, 4: lane count; width of all masks.
- STACK_DEPTH, 8: maximum number of nested divergences (≥1).
- DW = $clog2(STACK_DEPTH+1) (localparam): width of `depth`.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iHit  in  1  instruction fetch complete; the unit may advance.
- halt  in  1  decoded HALT.
- pc_sel  in  2  00: sequential/branch; 01: jump register; 10: jump; 11: same as 00.
- brEn  in  1  scalar branch taken (uniform across the warp).
- immExt  in  32  extended branch immediate (word offset).
- jaddr  in  26  jump target field.
- rdata1  in  32  jump-register target.
- vbr  in  1  current instruction is a vector branch.
- vcond  in  THREADS  per-lane branch condition; 1 = taken.
- reconv  in  1  current instruction is SYNC (reconvergence point).
- pc  out  32  current PC; drives `iaddr`.
- active_mask  out  THREADS  lanes enabled for the current instruction.
- depth  out  DW  number of valid stack entries.
- dhalt  out  1  core halted; sticky.
- stack_overflow  out  1  sticky error flag.

## Operation
- adv = iHit & !dhalt. When adv=0, all state holds.
- seq = pc+4; tgt = pc+4+(immExt<<2). All arithmetic is 32-bit, wraps mod 2^32, with no overflow detection.
- Stack entry fields: {pc_nt[31:0], mask_nt[THREADS], mask_full[THREADS], pending}.
- Priority when adv=1: halt > vbr > reconv > pc_sel.
- **halt:** dhalt<=1. PC and mask hold.
- **vbr:**
  - tk = vcond & active_mask; nt = ~vcond & active_mask.
  - tk==0: pc<=seq.
  - nt==0: pc<=tgt.
  - Otherwise (divergence), if depth<STACK_DEPTH:
    - push {seq, nt, active_mask, 1}.
    - pc<=tgt; active_mask<=tk; depth+1.
  - Divergence with depth==STACK_DEPTH: stack_overflow<=1, dhalt<=1. PC, mask and stack hold.
- **reconv:**
  - depth==0: pc<=seq (no-op).
  - Top entry pending=1: pc<=top.pc_nt, active_mask<=top.mask_nt, top.pending<=0. Depth is unchanged.
  - Top entry pending=0: pop. active_mask<=top.mask_full, pc<=seq, depth-1.
- **Otherwise, by pc_sel:**
  - 00/11: pc <= brEn ? tgt : seq.
  - 01: pc<=rdata1.
  - 10: pc<={pc[31:28],jaddr,2'b00}.
  - Mask and stack are unchanged.
- Scalar branches and jumps while a mask is partial move the whole warp and do not touch the stack. The program guarantees that each divergence has a matching SYNC pair.
- dhalt and stack_overflow clear only on reset.

## Timing
- All outputs are registered. Every update happens on the rising CLK edge where adv=1: one instruction per iHit, zero extra latency.
- Push, pop and pending-clear take effect in the same edge as the PC/mask update. The new `depth` and `active_mask` are visible in the next cycle.
- dhalt rises on the edge after HALT (or overflow) is sampled with adv=1. From then on pc is frozen even if iHit stays 1.
- Asynchronous reset, at any time including mid-divergence, forces:
  - pc=PC_INIT, active_mask=all ones, depth=0, all entries invalid, pending=0, dhalt=0, stack_overflow=0.
- Release from reset is synchronous to the first CLK edge. No output changes before that edge.

## Test plan
1. **Reset and sequential fetch:** reset, then iHit=1 for 3 cycles.
   - Required: pc 0→4→8→12, mask=1111, depth=0.
   - iHit=0 for 2 cycles: pc holds at 12.
2. **Uniform vector branch:** pc=0x10, vbr, immExt=3.
   - vcond=1111: pc=0x20, mask=1111, depth=0.
   - vcond=0000 from 0x10: pc=0x14.
3. **Divergence and reconvergence:** pc=0x10, vbr, vcond=0101, immExt=4.
   - pc=0x24, mask=0101, depth=1.
   - SYNC: pc=0x14, mask=1010, depth=1.
   - SYNC at pc=P: pc=P+4, mask=1111, depth=0.
4. **Nesting and overflow** (STACK_DEPTH=2):
   - Two divergences (1111→0011→0001): depth=2.
   - A third divergent vbr (vcond=0000 with mask 0001 is uniform, so use mask 0011 path with vcond=0010 at depth 2): stack_overflow=1, dhalt=1, pc frozen.
5. **Jumps and halt:**
   - pc_sel=01, rdata1=0x100: pc=0x100.
   - pc_sel=10 at pc=0x100, jaddr=0x40: pc=0x100.
   - halt: dhalt=1 next cycle; pc constant for 5 more cycles with iHit=1.
6. **Reset mid-divergence:** at depth=1, mask=0101, assert nRST=0 between edges.
   - Immediately: pc=0, mask=1111, depth=0, flags 0.
   - A subsequent SYNC: pc=4 only.
